// File: rtl/universal_shift_register.sv
// universal_shift_register
// Multi-cycle shift engine: loads a WIDTH-bit word, then performs 'amount'
// single-bit shifts, one per enabled clock. Supports shift-left,
// logical-right and arithmetic-right, with a start/busy/done handshake.
// Optional feature macro: USR_ROTATE_EN. When defined, mode 2'b11 rotates
// left; otherwise mode 2'b11 is a plain shift-left and no rotate path exists.
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             serialIn,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic             serialOut,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SHL  = 2'b00;
    localparam logic [1:0] MODE_LSR  = 2'b01;
    localparam logic [1:0] MODE_ASR  = 2'b10;
    localparam logic [1:0] MODE_ROTL = 2'b11;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] shift_data;
    logic             shift_out;

    // Next value of the word and the bit leaving it for one single-bit shift.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        shift_data = {dataout[WIDTH-2:0], serialIn};
        shift_out  = dataout[WIDTH-1];
        case (mode_q)
            MODE_SHL: begin
                shift_data = {dataout[WIDTH-2:0], serialIn};
                shift_out  = dataout[WIDTH-1];
            end
            MODE_LSR: begin
                shift_data = {serialIn, dataout[WIDTH-1:1]};
                shift_out  = dataout[0];
            end
            MODE_ASR: begin
                shift_data = {dataout[WIDTH-1], dataout[WIDTH-1:1]};
                shift_out  = dataout[0];
            end
            MODE_ROTL: begin
`ifdef USR_ROTATE_EN
                shift_data = {dataout[WIDTH-2:0], dataout[WIDTH-1]};
                shift_out  = dataout[WIDTH-1];
`else
                shift_data = {dataout[WIDTH-2:0], serialIn};
                shift_out  = dataout[WIDTH-1];
`endif
            end
            default: begin
                shift_data = {dataout[WIDTH-2:0], serialIn};
                shift_out  = dataout[WIDTH-1];
            end
        endcase
    end

    // Control FSM and datapath registers; enable=0 freezes everything, done included.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            mode_q    <= MODE_SHL;
            dataout   <= '0;
            serialOut <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        dataout <= datain;
                    end else if (start) begin
                        if (amount != '0) begin
                            mode_q <= mode;
                            count  <= amount;
                            state  <= SHIFT;
                            busy   <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    dataout   <= shift_data;
                    serialOut <= shift_out;
                    count     <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
